// File: rtl/decimal_to_bcd_key_encoder_pkg.sv
// Shared definitions for the decimal key encoder and the matching BCD display decoders.
// Holds the FSM state encoding, BCD width and the one-hot to BCD helper.
package decimal_to_bcd_key_encoder_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned KEYS  = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Index of the highest set key line; callers only pass one-hot vectors, so the result is 0..9
    function automatic logic [BCD_W-1:0] onehot10_to_bcd(input logic [KEYS-1:0] k);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(KEYS); i++) begin
            if (k[i]) begin
                r = BCD_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decimal_to_bcd_key_encoder_key_sync.sv
// Two-flop synchroniser for a vector of asynchronous key lines.
// Each bit is synchronised independently; no cross-bit coherency is implied.
module key_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/decimal_to_bcd_key_encoder.sv
// Ten-key decimal encoder: synchronise, debounce, encode one press to BCD,
// hand it off on valid/ready and shift accepted digits into the display register.
module decimal_to_bcd_key_encoder
    import decimal_to_bcd_key_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [KEYS-1:0]               key_in,
    input  logic                          clr,
    input  logic                          bcd_ready,
    output logic [BCD_W-1:0]              bcd_out,
    output logic                          bcd_valid,
    output logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output logic                          multi_err
);

    localparam int unsigned DW = BCD_W * NUM_DIGITS;
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [KEYS-1:0]  ks;
    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [KEYS-1:0]  cap;
    logic [KEYS-1:0]  cap_nxt;
    logic             bcd_valid_d;
    logic [BCD_W-1:0] bcd_out_d;
    logic             multi_err_d;
    logic             accept_c;

    key_sync #(
        .W (KEYS)
    ) u_key_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (ks)
    );

    assign accept_c = bcd_valid & bcd_ready;

    // State, counter, capture and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap       <= '0;
            bcd_valid <= 1'b0;
            bcd_out   <= '0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cap       <= cap_nxt;
            bcd_valid <= bcd_valid_d;
            bcd_out   <= bcd_out_d;
            multi_err <= multi_err_d;
        end
    end

    // Digit register: clr takes priority over a simultaneous transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
        end else if (clr) begin
            digits <= '0;
        end else if (accept_c) begin
            digits <= (digits << BCD_W) | DW'(bcd_out);
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_nxt   = cap;
        case (state)
            ST_IDLE: begin
                if ($onehot(ks)) begin
                    cap_nxt   = ks;
                    cnt_nxt   = '0;
                    state_nxt = ST_DEBOUNCE;
                end else if (ks != '0) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_DEBOUNCE: begin
                if (ks != cap) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_EMIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_EMIT: begin
                if (accept_c) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Only an unbroken run of all-released cycles returns to IDLE
                if (ks != '0) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values loaded into the output registers at the next edge
    always_comb begin
        bcd_valid_d = 1'b0;
        bcd_out_d   = '0;
        multi_err_d = 1'b0;
        if (state_nxt == ST_EMIT) begin
            bcd_valid_d = 1'b1;
            bcd_out_d   = onehot10_to_bcd(cap_nxt);
        end
        if ((state == ST_IDLE) && (ks != '0) && !$onehot(ks)) begin
            multi_err_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_decimal_to_bcd_key_encoder.sv
// Directed bench for the decimal key encoder with a digit scoreboard and a digits-register model.
module tb_decimal_to_bcd_key_encoder;
    import decimal_to_bcd_key_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  key_in;
    logic        clr;
    logic        bcd_ready;
    logic [3:0]  bcd_out;
    logic        bcd_valid;
    logic [15:0] digits;
    logic        multi_err;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] exp_digits = 16'h0000;

    decimal_to_bcd_key_encoder #(
        .DEBOUNCE_CYCLES (4),
        .NUM_DIGITS      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .clr       (clr),
        .bcd_ready (bcd_ready),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .digits    (digits),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bcd_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Pop the scoreboard head and compare it against the presented code
    task automatic check_emit(input string tag, output logic [3:0] e);
        bit ok;
        wait_valid(40, ok);
        chk({tag, "_timeout"}, 32'(ok), 32'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
        chk({tag, "_code"}, 32'(bcd_out), 32'(e));
    endtask

    task automatic press_accept(input int d);
        logic [3:0] e;
        key_in = 10'(1) << d;
        exp_q.push_back(4'(d));
        check_emit("press", e);
        exp_digits = {exp_digits[11:0], e};
        tick();
        chk("press_valid_drop", 32'(bcd_valid), 32'(0));
        chk("press_out_zero", 32'(bcd_out), 32'(0));
        chk("press_digits", 32'(digits), 32'(exp_digits));
        repeat (3) tick();
        key_in = '0;
        repeat (10) tick();
    endtask

    initial begin
        logic [3:0] e;
        rst       = 1'b1;
        key_in    = '0;
        clr       = 1'b0;
        bcd_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(bcd_valid), 32'(0));
        chk("rst_out", 32'(bcd_out), 32'(0));
        chk("rst_digits", 32'(digits), 32'(0));
        chk("rst_multi", 32'(multi_err), 32'(0));
        rst = 1'b0;
        bcd_ready = 1'b1;
        tick();

        // Key 7 held 20 cycles: exact latency and a single valid cycle
        key_in = 10'b00_1000_0000;
        exp_q.push_back(4'd7);
        repeat (6) tick();
        chk("lat_early", 32'(bcd_valid), 32'(0));
        tick();
        chk("lat_valid", 32'(bcd_valid), 32'(1));
        e = exp_q.pop_front();
        chk("lat_code", 32'(bcd_out), 32'(e));
        exp_digits = {exp_digits[11:0], e};
        tick();
        chk("lat_drop", 32'(bcd_valid), 32'(0));
        chk("lat_digits", 32'(digits), 32'(exp_digits));
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("hold_no_repeat", 32'(bcd_valid), 32'(0));
        end
        key_in = '0;
        repeat (10) tick();

        // Digits 1..5, oldest drops off the top
        for (int d = 1; d <= 5; d++) press_accept(d);
        chk("wrap_digits", 32'(digits), 32'(16'h2345));

        // Key 9 with backpressure; release during EMIT has no effect
        bcd_ready = 1'b0;
        key_in = 10'b10_0000_0000;
        exp_q.push_back(4'd9);
        check_emit("bp", e);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) key_in = '0;
            chk("bp_valid", 32'(bcd_valid), 32'(1));
            chk("bp_code", 32'(bcd_out), 32'(e));
            chk("bp_digits", 32'(digits), 32'(exp_digits));
        end
        bcd_ready = 1'b1;
        exp_digits = {exp_digits[11:0], e};
        tick();
        chk("bp_drop", 32'(bcd_valid), 32'(0));
        chk("bp_digits_after", 32'(digits), 32'(exp_digits));
        repeat (10) tick();

        // Bouncing key 3: high 2, low 1, then stable
        key_in = 10'b00_0000_1000;
        repeat (2) tick();
        key_in = '0;
        tick();
        key_in = 10'b00_0000_1000;
        exp_q.push_back(4'd3);
        repeat (6) tick();
        chk("bounce_early", 32'(bcd_valid), 32'(0));
        tick();
        chk("bounce_valid", 32'(bcd_valid), 32'(1));
        e = exp_q.pop_front();
        chk("bounce_code", 32'(bcd_out), 32'(e));
        exp_digits = {exp_digits[11:0], e};
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bounce_single", 32'(bcd_valid), 32'(0));
        end
        chk("bounce_digits", 32'(digits), 32'(exp_digits));
        key_in = '0;
        repeat (10) tick();

        // Keys 2 and 6 together: one multi_err pulse, no digit
        key_in = 10'b00_0100_0100;
        repeat (2) tick();
        chk("multi_early", 32'(multi_err), 32'(0));
        tick();
        chk("multi_pulse", 32'(multi_err), 32'(1));
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("multi_once", 32'(multi_err), 32'(0));
            chk("multi_no_valid", 32'(bcd_valid), 32'(0));
        end
        key_in = '0;
        repeat (10) tick();
        press_accept(8);
        chk("after_multi_digits", 32'(digits), 32'(16'h5938));

        // clr coinciding with an accepting transfer
        bcd_ready = 1'b0;
        key_in = 10'b00_0000_0010;
        exp_q.push_back(4'd1);
        check_emit("clr", e);
        clr = 1'b1;
        bcd_ready = 1'b1;
        tick();
        clr = 1'b0;
        exp_digits = 16'h0000;
        chk("clr_digits", 32'(digits), 32'(exp_digits));
        chk("clr_valid_drop", 32'(bcd_valid), 32'(0));
        chk("clr_state", 32'(dut.state), 32'(ST_RELEASE));
        key_in = '0;
        repeat (10) tick();

        // Reset while a digit is being presented
        bcd_ready = 1'b0;
        key_in = 10'b00_0010_0000;
        exp_q.push_back(4'd5);
        check_emit("rst_mid", e);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(bcd_valid), 32'(0));
        chk("rstmid_out", 32'(bcd_out), 32'(0));
        chk("rstmid_digits", 32'(digits), 32'(0));
        chk("rstmid_multi", 32'(multi_err), 32'(0));
        key_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        bcd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rstmid_no_stale", 32'(bcd_valid), 32'(0));
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
